pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central hazard and pipeline-control block for the 5-stage pipelined CPU. It sits beside the IF/ID, ID/EX and EX/MEM registers and decides, every cycle, whether each pipeline register loads, holds, or loads a bubble. It also produces registered forwarding selects that are aligned with the instruction entering EX, and it counts stall and flush events for performance debug.

## Interface
Parameters:
- MEM_TIMEOUT, 64: maximum data-memory wait cycles before `mem_timeout_err` sets.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  core clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- id_rs1, id_rs2  in  5  source register numbers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1  the ID instruction really reads rs1 / rs2.
- ex_rd_in  in  5  destination register of the instruction in EX.
- ex_reg_wr_in  in  1  the EX instruction writes the register file.
- ex_mem_reg_in  in  1  the EX instruction is a load.
- mem_rd  in  5  destination register of the instruction in MEM.
- mem_reg_wr  in  1  the MEM instruction writes the register file.
- mem_access  in  1  the MEM instruction performs a data-memory load or store.
- dmem_ready  in  1  data memory completes the current access this cycle.
- ex_branch_taken  in  1  the EX stage resolved a taken branch or jump this cycle.
- pc_hold, if_id_hold  out  1  the PC and IF/ID register keep their value.
- if_id_flush  out  1  IF/ID loads a NOP.
- id_ex_hold  out  1  ID/EX keeps its value.
- id_ex_bubble  out  1  ID/EX loads all-zero controls.
- ex_mem_hold, mem_wb_hold  out  1  EX/MEM and MEM/WB keep their value.
- fwd_a_sel, fwd_b_sel  out  2  operand source for the instruction in EX: 00 = register file, 01 = EX/MEM, 10 = MEM/WB.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.
- mem_timeout_err  out  1  sticky error: the data-memory wait exceeded MEM_TIMEOUT.

## Operation
- **Hold/flush outputs.** These are combinational from the current inputs and state. The pipeline registers sample them at the same clock edge.
- **States.**
  - RUN: normal operation.
  - MEMWAIT: the pipeline is frozen waiting on data memory.
- **Freeze condition.** freeze = mem_access & !dmem_ready.
- **RUN → MEMWAIT.** Taken when freeze is asserted. The freeze outputs are asserted in that same cycle.
- **MEMWAIT → RUN.** Taken on the cycle dmem_ready = 1.
- **Freeze outputs.** While freeze is asserted, all of these are 1: pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, mem_wb_hold. if_id_flush and id_ex_bubble are forced to 0.
- **Load-use hazard.** Asserted when ex_mem_reg_in & ex_reg_wr_in & ex_rd_in≠0 & ((id_uses_rs1 & id_rs1==ex_rd_in) | (id_uses_rs2 & id_rs2==ex_rd_in)).
  - Response: pc_hold = 1, if_id_hold = 1, id_ex_bubble = 1.
  - Lasts exactly one cycle, because the load then advances to MEM.
- **Taken branch.** When ex_branch_taken = 1: if_id_flush = 1 and id_ex_bubble = 1; the PC loads the target, so pc_hold = 0.
- **Priority.** reset > freeze > branch flush > load-use.
  - A load-use hazard in the same cycle as a taken branch is ignored, because the ID instruction is being killed anyway.
- **Forwarding registers.** fwd_a_sel and fwd_b_sel are registered and update only when ID/EX advances, i.e. when not frozen.
  - Bubble or flush: the next value is 00.
  - Otherwise, for each source operand:
    - 01 if ex_reg_wr_in, ex_rd_in≠0, the rs matches ex_rd_in and the operand is used;
    - else 10 if mem_reg_wr, mem_rd≠0, the rs matches mem_rd and the operand is used;
    - else 00.
  - The EX match has priority over the MEM match.
  - Register x0 never forwards.
- **Performance counters.**
  - stall_cnt increments on every freeze cycle and every load-use stall cycle.
  - flush_cnt increments on every taken-branch cycle.
  - Both saturate at all-ones; they do not wrap.
- **Memory timeout.** A wait counter counts consecutive freeze cycles.
  - It clears when dmem_ready = 1.
  - When it reaches MEM_TIMEOUT, mem_timeout_err sets. Only reset clears it.
  - The freeze continues after the error sets.

## Timing
- **Reset values.** When reset is sampled high: state = RUN, fwd selects = 00, both counters = 0, wait counter = 0, mem_timeout_err = 0.
- **Outputs during reset.** While reset = 1, all hold, flush and bubble outputs are 0.
- **Reset mid-wait.** Reset asserted during MEMWAIT returns to RUN on the next edge, with no residual hold.
- **Load-use latency.** Exactly one bubble cycle. The dependent instruction then enters EX with the select for the load's register = 10.
- **Branch penalty.** Exactly 2 instructions are killed (one in IF/ID, one in ID/EX) with zero stall cycles.
- **Forwarding validity.** A select value is valid for the whole cycle its instruction occupies EX, including any frozen cycles.
- **Single-cycle memory.** dmem_ready = 1 in the same cycle as mem_access produces no freeze and never enters MEMWAIT.

## Structure
- **Shared package cpu_pkg:**
  - the state encoding;
  - the forwarding constants FWD_RF = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10.
- **Sub-module fwd_select.** Combinational next-select logic, instantiated twice (once for operand A, once for operand B). All remaining logic stays in the top module.

## Test plan
1. `lw x5` in EX while ID holds `add x6,x5,x1` with uses_rs1 = 1 → one cycle of pc_hold = if_id_hold = id_ex_bubble = 1; the next cycle fwd_a_sel = 10; stall_cnt = 1.
2. `add x3` in EX and `add x3` in MEM, with ID reading x3 on rs2 → fwd_b_sel = 01 after the edge (EX has priority); with ex_rd_in = 0 and rs2 = 0 → fwd_b_sel = 00.
3. ex_branch_taken = 1 in the same cycle as a load-use match → if_id_flush = id_ex_bubble = 1, pc_hold = 0, flush_cnt += 1, stall_cnt unchanged.
4. mem_access = 1 with dmem_ready low for 3 cycles → all five hold outputs = 1 for 3 cycles, branch and bubble outputs suppressed, fwd selects stable, stall_cnt = 3, then RUN.
5. MEM_TIMEOUT = 4 and dmem_ready held low for 6 cycles → mem_timeout_err rises after the 4th freeze cycle and stays high after ready returns; reset asserted mid-wait → all outputs reset values on the next cycle.
6. stall_cnt preloaded near saturation (CNT_W = 4) → counter stops at 15 and does not wrap.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage pipeline control logic.
//   hz_state_t : hazard controller state encoding (RUN / MEMWAIT)
//   FWD_*      : operand-source select codes driven to the EX-stage operand muxes
package cpu_pkg;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MEMWAIT = 1'b1
    } hz_state_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

endpackage

// File: rtl/fwd_select.sv
// Next forwarding select for one EX source operand.
// Ports:
//   rs, uses            : source register of the ID instruction and whether it is read
//   ex_rd, ex_reg_wr    : destination / write-enable of the instruction now in EX
//   mem_rd, mem_reg_wr  : destination / write-enable of the instruction now in MEM
//   kill                : ID/EX is loading a bubble, so the select must be FWD_RF
//   sel                 : select the ID instruction will need once it reaches EX
module fwd_select
    import cpu_pkg::*;
(
    input  logic [4:0] rs,
    input  logic       uses,
    input  logic [4:0] ex_rd,
    input  logic       ex_reg_wr,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_wr,
    input  logic       kill,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        if (!kill && uses) begin
            // The younger producer (EX) wins; x0 is never forwarded.
            if (ex_reg_wr && (ex_rd != 5'd0) && (rs == ex_rd))
                sel = FWD_EXMEM;
            else if (mem_reg_wr && (mem_rd != 5'd0) && (rs == mem_rd))
                sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and pipeline-control block for the 5-stage CPU.
// Decides each cycle whether the pipeline registers load, hold or take a bubble,
// registers the forwarding selects for the instruction entering EX, counts stall
// and flush events, and flags data-memory waits that exceed MEM_TIMEOUT.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   id_rs1/2, id_uses_rs1/2         : sources of the ID instruction
//   ex_rd_in, ex_reg_wr_in,
//   ex_mem_reg_in                   : EX instruction destination / write / is-load
//   mem_rd, mem_reg_wr, mem_access  : MEM instruction destination / write / memory op
//   dmem_ready                      : data memory completes this cycle
//   ex_branch_taken                 : EX resolved a taken branch/jump
//   pc_hold ... mem_wb_hold         : combinational hold/flush/bubble controls
//   fwd_a_sel, fwd_b_sel            : registered operand selects for EX
//   stall_cnt, flush_cnt            : saturating event counters
//   mem_timeout_err                 : sticky memory-wait timeout flag
module pipeline_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd_in,
    input  logic             ex_reg_wr_in,
    input  logic             ex_mem_reg_in,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_wr,
    input  logic             mem_access,
    input  logic             dmem_ready,
    input  logic             ex_branch_taken,
    output logic             pc_hold,
    output logic             if_id_hold,
    output logic             if_id_flush,
    output logic             id_ex_hold,
    output logic             id_ex_bubble,
    output logic             ex_mem_hold,
    output logic             mem_wb_hold,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout_err
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    hz_state_t         state, state_next;
    logic              freeze;
    logic              load_use;
    logic              stall_evt;
    logic              flush_evt;
    logic [1:0]        fwd_a_next, fwd_b_next;
    logic [WAIT_W-1:0] wait_cnt;

    assign freeze = mem_access & ~dmem_ready;

    assign load_use = ex_mem_reg_in & ex_reg_wr_in & (ex_rd_in != 5'd0) &
                      ((id_uses_rs1 & (id_rs1 == ex_rd_in)) |
                       (id_uses_rs2 & (id_rs2 == ex_rd_in)));

    always_ff @(posedge clk) begin
        if (reset) state <= ST_RUN;
        else       state <= state_next;
    end

    // Priority: reset > freeze > branch flush > load-use.
    always_comb begin
        state_next   = state;
        pc_hold      = 1'b0;
        if_id_hold   = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_hold   = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_hold  = 1'b0;
        mem_wb_hold  = 1'b0;
        stall_evt    = 1'b0;
        flush_evt    = 1'b0;

        case (state)
            ST_RUN:     if (freeze)     state_next = ST_MEMWAIT;
            ST_MEMWAIT: if (dmem_ready) state_next = ST_RUN;
            default:                    state_next = ST_RUN;
        endcase

        if (reset) begin
            state_next = ST_RUN;
        end else if (freeze) begin
            pc_hold     = 1'b1;
            if_id_hold  = 1'b1;
            id_ex_hold  = 1'b1;
            ex_mem_hold = 1'b1;
            mem_wb_hold = 1'b1;
            stall_evt   = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_evt    = 1'b1;
        end else if (load_use) begin
            pc_hold      = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_bubble = 1'b1;
            stall_evt    = 1'b1;
        end
    end

    fwd_select u_fwd_a (
        .rs         (id_rs1),
        .uses       (id_uses_rs1),
        .ex_rd      (ex_rd_in),
        .ex_reg_wr  (ex_reg_wr_in),
        .mem_rd     (mem_rd),
        .mem_reg_wr (mem_reg_wr),
        .kill       (id_ex_bubble),
        .sel        (fwd_a_next)
    );

    fwd_select u_fwd_b (
        .rs         (id_rs2),
        .uses       (id_uses_rs2),
        .ex_rd      (ex_rd_in),
        .ex_reg_wr  (ex_reg_wr_in),
        .mem_rd     (mem_rd),
        .mem_reg_wr (mem_reg_wr),
        .kill       (id_ex_bubble),
        .sel        (fwd_b_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_a_sel       <= FWD_RF;
            fwd_b_sel       <= FWD_RF;
            stall_cnt       <= '0;
            flush_cnt       <= '0;
            wait_cnt        <= '0;
            mem_timeout_err <= 1'b0;
        end else begin
            // Selects travel with ID/EX, so they hold whenever it holds.
            if (!freeze) begin
                fwd_a_sel <= fwd_a_next;
                fwd_b_sel <= fwd_b_next;
            end
            if (stall_evt && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_evt && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
            // Wait counter tracks consecutive freeze cycles and parks at the limit.
            if (freeze) begin
                if (wait_cnt != WAIT_MAX)
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                if (wait_cnt >= WAIT_LAST)
                    mem_timeout_err <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2;
    logic       id_uses_rs1, id_uses_rs2;
    logic [4:0] ex_rd_in;
    logic       ex_reg_wr_in, ex_mem_reg_in;
    logic [4:0] mem_rd;
    logic       mem_reg_wr, mem_access, dmem_ready, ex_branch_taken;
    logic       pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_bubble;
    logic       ex_mem_hold, mem_wb_hold;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic [3:0] stall_cnt, flush_cnt;
    logic       mem_timeout_err;

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT (4),
        .CNT_W       (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rd_in        (ex_rd_in),
        .ex_reg_wr_in    (ex_reg_wr_in),
        .ex_mem_reg_in   (ex_mem_reg_in),
        .mem_rd          (mem_rd),
        .mem_reg_wr      (mem_reg_wr),
        .mem_access      (mem_access),
        .dmem_ready      (dmem_ready),
        .ex_branch_taken (ex_branch_taken),
        .pc_hold         (pc_hold),
        .if_id_hold      (if_id_hold),
        .if_id_flush     (if_id_flush),
        .id_ex_hold      (id_ex_hold),
        .id_ex_bubble    (id_ex_bubble),
        .ex_mem_hold     (ex_mem_hold),
        .mem_wb_hold     (mem_wb_hold),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .mem_timeout_err (mem_timeout_err)
    );

    always #5 clk = ~clk;

    // ctl order: {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_bubble, ex_mem_hold, mem_wb_hold}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_FRZ  = 7'b1101011;
    localparam logic [6:0] C_LU   = 7'b1100100;
    localparam logic [6:0] C_BR   = 7'b0010100;

    typedef struct {
        logic       regs;
        logic [6:0] ctl;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [3:0] st;
        logic [3:0] fl;
        logic       er;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc_no   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL cycle %0d %s: got %0h expected %0h", cyc_no, nm, act, exp);
    endtask

    // Monitor: outputs of the cycle are sampled mid-cycle, one queued expectation per cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            cyc_no++;
            e = sb.pop_front();
            chk("ctl", 32'({pc_hold, if_id_hold, if_id_flush, id_ex_hold,
                            id_ex_bubble, ex_mem_hold, mem_wb_hold}), 32'(e.ctl));
            if (e.regs) begin
                chk("fwd_a_sel", 32'(fwd_a_sel), 32'(e.fa));
                chk("fwd_b_sel", 32'(fwd_b_sel), 32'(e.fb));
                chk("stall_cnt", 32'(stall_cnt), 32'(e.st));
                chk("flush_cnt", 32'(flush_cnt), 32'(e.fl));
                chk("mem_timeout_err", 32'(mem_timeout_err), 32'(e.er));
            end
        end
    end

    task automatic idle();
        reset = 1'b0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_rd_in = 5'd0; ex_reg_wr_in = 1'b0; ex_mem_reg_in = 1'b0;
        mem_rd = 5'd0; mem_reg_wr = 1'b0; mem_access = 1'b0; dmem_ready = 1'b0;
        ex_branch_taken = 1'b0;
    endtask

    // lw x5 in EX, add x6,x5,x1 in ID
    task automatic load_use_inputs();
        ex_rd_in = 5'd5; ex_reg_wr_in = 1'b1; ex_mem_reg_in = 1'b1;
        id_rs1 = 5'd5; id_uses_rs1 = 1'b1; id_rs2 = 5'd1; id_uses_rs2 = 1'b1;
    endtask

    task automatic freeze_inputs();
        idle();
        mem_access = 1'b1; dmem_ready = 1'b0;
    endtask

    // Queue this cycle's expectation, then move to the next cycle.
    task automatic step(input logic regs, input logic [6:0] ctl, input logic [1:0] fa,
                        input logic [1:0] fb, input logic [3:0] st, input logic [3:0] fl,
                        input logic er);
        exp_t x;
        x.regs = regs; x.ctl = ctl; x.fa = fa; x.fb = fb; x.st = st; x.fl = fl; x.er = er;
        sb.push_back(x);
        @(posedge clk); #1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clk); #1;

        // Reset: controls forced low even with freeze/branch inputs active.
        idle(); reset = 1'b1; mem_access = 1'b1; ex_branch_taken = 1'b1;
        step(1'b0, C_NONE, 2'b00, 2'b00, 4'd0, 4'd0, 1'b0);
        step(1'b1, C_NONE, 2'b00, 2'b00, 4'd0, 4'd0, 1'b0);

        // Load-use: one bubble, then x5 comes from MEM/WB.
        idle(); load_use_inputs();
        step(1'b1, C_LU, 2'b00, 2'b00, 4'd0, 4'd0, 1'b0);
        idle(); mem_rd = 5'd5; mem_reg_wr = 1'b1; mem_access = 1'b1; dmem_ready = 1'b1;
        id_rs1 = 5'd5; id_uses_rs1 = 1'b1; id_rs2 = 5'd1; id_uses_rs2 = 1'b1;
        step(1'b1, C_NONE, 2'b00, 2'b00, 4'd1, 4'd0, 1'b0);
        idle();
        step(1'b1, C_NONE, 2'b10, 2'b00, 4'd1, 4'd0, 1'b0);

        // EX beats MEM on rs2; x0 never forwards; unused operand never forwards.
        idle(); ex_rd_in = 5'd3; ex_reg_wr_in = 1'b1; mem_rd = 5'd3; mem_reg_wr = 1'b1;
        id_rs2 = 5'd3; id_uses_rs2 = 1'b1;
        step(1'b1, C_NONE, 2'b00, 2'b00, 4'd1, 4'd0, 1'b0);
        idle(); ex_reg_wr_in = 1'b1; mem_reg_wr = 1'b1; id_uses_rs2 = 1'b1;
        step(1'b1, C_NONE, 2'b00, 2'b01, 4'd1, 4'd0, 1'b0);
        idle(); ex_rd_in = 5'd7; ex_reg_wr_in = 1'b1; mem_rd = 5'd9; mem_reg_wr = 1'b1;
        id_rs1 = 5'd9; id_uses_rs1 = 1'b1; id_rs2 = 5'd7; id_uses_rs2 = 1'b0;
        step(1'b1, C_NONE, 2'b00, 2'b00, 4'd1, 4'd0, 1'b0);
        idle();
        step(1'b1, C_NONE, 2'b10, 2'b00, 4'd1, 4'd0, 1'b0);

        // Branch and load-use together: branch wins, no stall counted.
        idle(); load_use_inputs(); ex_branch_taken = 1'b1;
        step(1'b1, C_BR, 2'b00, 2'b00, 4'd1, 4'd0, 1'b0);
        idle(); ex_rd_in = 5'd2; ex_reg_wr_in = 1'b1; id_rs1 = 5'd2; id_uses_rs1 = 1'b1;
        step(1'b1, C_NONE, 2'b00, 2'b00, 4'd1, 4'd1, 1'b0);

        // 3-cycle freeze with branch/load-use inputs suppressed; fwd_a stays 01.
        for (int i = 0; i < 3; i++) begin
            freeze_inputs(); ex_branch_taken = 1'b1; ex_mem_reg_in = 1'b1;
            ex_rd_in = 5'd2; ex_reg_wr_in = 1'b1; id_rs1 = 5'd2; id_uses_rs1 = 1'b1;
            step(1'b1, C_FRZ, 2'b01, 2'b00, 4'(1 + i), 4'd1, 1'b0);
        end
        idle(); mem_access = 1'b1; dmem_ready = 1'b1;
        step(1'b1, C_NONE, 2'b01, 2'b00, 4'd4, 4'd1, 1'b0);
        idle();
        step(1'b1, C_NONE, 2'b00, 2'b00, 4'd4, 4'd1, 1'b0);

        // Timeout 4: six-cycle wait, error visible after the 4th freeze cycle.
        for (int i = 0; i < 6; i++) begin
            freeze_inputs();
            step(1'b1, C_FRZ, 2'b00, 2'b00, 4'(4 + i), 4'd1, (i >= 4) ? 1'b1 : 1'b0);
        end
        idle(); mem_access = 1'b1; dmem_ready = 1'b1;
        step(1'b1, C_NONE, 2'b00, 2'b00, 4'd10, 4'd1, 1'b1);
        idle();
        step(1'b1, C_NONE, 2'b00, 2'b00, 4'd10, 4'd1, 1'b1);

        // Reset in the middle of a wait: nothing held afterwards.
        freeze_inputs();
        step(1'b1, C_FRZ, 2'b00, 2'b00, 4'd10, 4'd1, 1'b1);
        freeze_inputs(); reset = 1'b1;
        step(1'b1, C_NONE, 2'b00, 2'b00, 4'd11, 4'd1, 1'b1);
        idle();
        step(1'b1, C_NONE, 2'b00, 2'b00, 4'd0, 4'd0, 1'b0);

        // Saturation of the 4-bit stall counter over a 17-cycle freeze.
        for (int i = 0; i < 17; i++) begin
            freeze_inputs();
            step(1'b1, C_FRZ, 2'b00, 2'b00, (i > 15) ? 4'd15 : 4'(i), 4'd0,
                 (i >= 4) ? 1'b1 : 1'b0);
        end
        idle(); mem_access = 1'b1; dmem_ready = 1'b1;
        step(1'b1, C_NONE, 2'b00, 2'b00, 4'd15, 4'd0, 1'b1);
        idle();
        step(1'b1, C_NONE, 2'b00, 2'b00, 4'd15, 4'd0, 1'b1);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, required 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
